contador_modular: RTL and testbench
===================================

// Module: contador_modular
// PURPOSE
//  Parametrised synchronous up/down counter. It is the successor to the JK ripple counter.
//  All bits share clk, so there is no ripple skew.
//  The active-bit selection (cant_ff) is kept and extended with: direction, load, sync clear,
//  wrap/saturate/one-shot modes, and a terminal-count pulse.
//  Used as the lab's general event/divider counter feeding displays and timing logic.
// PARAMETERS
//  WIDTH   6   counter width in bits (1..32)
//  CW      $clog2(WIDTH+1)   width of cant_ff (derived, not overridden)
// PORTS
//  clk       in   1      sole clock, rising edge
//  rst       in   1      asynchronous, active-low reset
//  ena       in   1      count enable, sampled on rising clk
//  dir       in   1      1 = count up, 0 = count down
//  mode      in   2      00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
//  cant_ff   in   CW     number of active low-order bits k; k > WIDTH clamps to WIDTH
//  clr       in   1      synchronous clear
//  load      in   1      synchronous load
//  load_val  in   WIDTH  load value (masked to k bits)
//  num       out  WIDTH  count value, registered
//  tc        out  1      terminal-count pulse, registered
//  done      out  1      one-shot finished, sticky
// BEHAVIOUR
//  - Reset (rst=0, async): num=0, tc=0, done=0, FSM=ST_RUN. Outputs held while rst=0.
//    First rising edge after rst=1 operates normally.
//  - max = (1<<k)-1. Bits >= k of num are always 0. k=0: num=0, tc=0, counter inert.
//  - Priority per edge: clr > load > count > mask-fix.
//  - clr: num=0, done=0, FSM=ST_RUN, tc=0.
//  - load: num=load_val&max, done=0, FSM=ST_RUN, tc=0. Load never raises tc.
//  - Count, when ena=1 and FSM=ST_RUN: num+1 (up) or num-1 (down), single-cycle latency.
//  - Terminal value T: max when counting up, 0 when counting down.
//  - Count step when num==T:
//      wrap      up: max->0; down: 0->max.
//      saturate  num holds at T.
//      one-shot  num holds at T; FSM->ST_DONE; done=1.
//  - tc=1 for exactly one cycle, on the edge where a count step makes num==T
//    (i.e. num!=T before the step). Saturate/one-shot holds at T give no further pulses.
//    Wrap gives one pulse per period.
//  - ST_DONE: ena ignored. Exit only via clr or load.
//    A mode change away from one-shot also returns to ST_RUN with done=0.
//  - cant_ff change: next edge num = num & new max, even if ena=0.
//    The masking edge never pulses tc.
//  - dir change mid-count takes effect on the next enabled edge. No extra step is taken.
//  - All arithmetic is WIDTH bits, modulo 2^WIDTH, and the result is masked with max.
// STRUCTURE
//  - contador_pkg: typedef enum logic[1:0] mode_t {M_WRAP, M_SAT, M_ONESHOT, M_RSV};
//    typedef enum logic st_t {ST_RUN, ST_DONE}.
//  - Sub-module contador_mask_gen (combinational): cant_ff -> clamped k, max mask, is_zero flag.
//  - Top: one always_ff holds num, tc, done and FSM. Next-state logic is in always_comb.
// TESTING (WIDTH=8)
//  1. k=4, up, wrap, ena=1 from 0 -> num 1..15; tc=1 only on the edge num=15;
//     next edge num=0; 2nd period same.
//  2. load_val=3, down, saturate -> num 3,2,1,0,0,0; tc high once, at num=0.
//  3. k=3, up, one-shot from 0 -> num reaches 7; done=1, tc once; 5 more ena edges num=7;
//     clr -> num=0, done=0.
//  4. k=4, load 0xFF -> num=0x0F, tc=0. Then k=8, load 0xA5, change to k=2 with ena=0
//     -> next edge num=0x01.
//  5. Count to 0x22, drop rst between edges -> num=0 immediately, held while rst=0;
//     release, ena=1 -> num=1.
//  6. clr and load same edge -> num=0. k=0 with ena=1 for 10 edges -> num=0, tc=0 throughout.

Source files
------------

// File: rtl/contador_modular_pkg.sv
// Shared types for the modular synchronous counter: counting modes and run/done states.
package contador_pkg;

  typedef enum logic [1:0] {
    M_WRAP    = 2'b00,
    M_SAT     = 2'b01,
    M_ONESHOT = 2'b10,
    M_RSV     = 2'b11
  } mode_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } st_t;

endpackage

// File: rtl/contador_modular_if.sv
// Control/status bundle of the modular counter; the counter is the slave side.
interface contador_modular_if #(
  parameter int WIDTH = 6
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             ena;
  logic             dir;
  logic [1:0]       mode;
  logic [CW-1:0]    cant_ff;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] num;
  logic             tc;
  logic             done;

  modport master (
    output ena, dir, mode, cant_ff, clr, load, load_val,
    input  num, tc, done
  );

  modport slave (
    input  ena, dir, mode, cant_ff, clr, load, load_val,
    output num, tc, done
  );
endinterface

// File: rtl/contador_modular_mask_gen.sv
// Turns the requested active-bit count into a clamped low-order mask and an
// "all bits disabled" flag.
module contador_modular_mask_gen #(
  parameter int WIDTH = 6,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [CW-1:0]    cant_ff,
  output logic [WIDTH-1:0] max_mask,
  output logic             is_zero
);

  logic [CW-1:0] k_s;

  // Clamp k to WIDTH, then build the mask bit by bit so k=WIDTH=32 never overflows a shift.
  always_comb begin
    k_s      = cant_ff;
    max_mask = {WIDTH{1'b0}};
    if (cant_ff > CW'(WIDTH)) begin
      k_s = CW'(WIDTH);
    end else begin
      k_s = cant_ff;
    end
    for (int i = 0; i < WIDTH; i++) begin
      max_mask[i] = (i < int'(k_s));
    end
    is_zero = (k_s == {CW{1'b0}});
  end

endmodule

// File: rtl/contador_modular.sv
// Parametrised synchronous up/down counter with active-bit selection, load, clear,
// wrap/saturate/one-shot modes and a registered terminal-count pulse.
module contador_modular
  import contador_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input logic               clk,
  input logic               rst,
  contador_modular_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] num_r, num_s;
  logic             tc_r, tc_s;
  logic             done_r, done_s;
  st_t              st_r, st_s;
  logic [WIDTH-1:0] max_s, term_s, step_s;
  logic             zero_s;
  mode_t            mode_s;

  contador_modular_mask_gen #(.WIDTH(WIDTH), .CW(CW)) u_mask (
    .cant_ff  (bus.cant_ff),
    .max_mask (max_s),
    .is_zero  (zero_s)
  );

  assign mode_s = mode_t'(bus.mode);

  // Next-state: clr > load > done-exit > count > mask-fix; every path re-masks num.
  always_comb begin
    num_s  = num_r & max_s;
    tc_s   = 1'b0;
    done_s = done_r;
    st_s   = st_r;
    if (bus.dir) begin
      term_s = max_s;
      step_s = num_r + WIDTH'(1);
    end else begin
      term_s = {WIDTH{1'b0}};
      step_s = num_r - WIDTH'(1);
    end
    if (bus.clr) begin
      num_s  = {WIDTH{1'b0}};
      done_s = 1'b0;
      st_s   = ST_RUN;
    end else if (bus.load) begin
      num_s  = bus.load_val & max_s;
      done_s = 1'b0;
      st_s   = ST_RUN;
    end else if (st_r == ST_DONE) begin
      // Leaving one-shot mode releases the finished counter; ena is ignored here.
      if (mode_s != M_ONESHOT) begin
        st_s   = ST_RUN;
        done_s = 1'b0;
      end else begin
        st_s = ST_DONE;
      end
    end else if (bus.ena && !zero_s) begin
      if (num_r == term_s) begin
        case (mode_s)
          M_SAT: begin
            num_s = term_s;
          end
          M_ONESHOT: begin
            num_s  = term_s;
            st_s   = ST_DONE;
            done_s = 1'b1;
          end
          M_WRAP, M_RSV: begin
            num_s = bus.dir ? {WIDTH{1'b0}} : max_s;
          end
          default: begin
            num_s = bus.dir ? {WIDTH{1'b0}} : max_s;
          end
        endcase
      end else begin
        num_s = step_s & max_s;
        tc_s  = ((step_s & max_s) == term_s);
      end
    end else begin
      num_s = num_r & max_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_r  <= {WIDTH{1'b0}};
      tc_r   <= 1'b0;
      done_r <= 1'b0;
      st_r   <= ST_RUN;
    end else begin
      num_r  <= num_s;
      tc_r   <= tc_s;
      done_r <= done_s;
      st_r   <= st_s;
    end
  end

  assign bus.num  = num_r;
  assign bus.tc   = tc_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_contador_modular.sv
// Self-checking bench for contador_modular (WIDTH=8): directed scenarios plus random
// stimulus against a behavioural model evaluated on every clock edge.
module tb_contador_modular;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  bit   check_en;

  // behavioural model state
  int m_num;
  int m_tc;
  int m_done;
  int m_run;

  contador_modular_if #(.WIDTH(W)) bus ();

  contador_modular #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, got, got, exp, exp, $time);
    end
  endtask

  // Model: next outputs from the counter's rules using plain integer arithmetic.
  task automatic model_step();
    int k, mx, t, nxt;
    k  = (int'(bus.cant_ff) > W) ? W : int'(bus.cant_ff);
    mx = (1 << k) - 1;
    t  = bus.dir ? mx : 0;
    m_tc = 0;
    if (bus.clr) begin
      m_num = 0; m_done = 0; m_run = 1;
    end else if (bus.load) begin
      m_num = int'(bus.load_val) & mx; m_done = 0; m_run = 1;
    end else if (!m_run) begin
      if (bus.mode != 2'd2) begin m_run = 1; m_done = 0; end
      m_num = m_num & mx;
    end else if (bus.ena && k > 0) begin
      if (m_num == t) begin
        if (bus.mode == 2'd1) m_num = t;
        else if (bus.mode == 2'd2) begin m_num = t; m_run = 0; m_done = 1; end
        else m_num = bus.dir ? 0 : mx;
      end else begin
        nxt   = bus.dir ? (m_num + 1) % 256 : (m_num + 255) % 256;
        m_num = nxt & mx;
        m_tc  = (m_num == t) ? 1 : 0;
      end
    end else begin
      m_num = m_num & mx;
    end
  endtask

  // Single compare process: update the model at each edge (or async reset), check #1 later.
  initial begin
    m_num = 0; m_tc = 0; m_done = 0; m_run = 1;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_num = 0; m_tc = 0; m_done = 0; m_run = 1;
      end else begin
        model_step();
      end
      #1;
      if (check_en) begin
        chk("model num", int'(bus.num), m_num);
        chk("model tc", int'(bus.tc), m_tc);
        chk("model done", int'(bus.done), m_done);
      end
    end
  end

  task automatic edge_();
    @(negedge clk);
  endtask

  // Literal pins: DUT and model both against hand-computed values.
  task automatic pin(input string nm, input int en, input int et, input int ed);
    chk({nm, " num"}, int'(bus.num), en);
    chk({nm, " tc"}, int'(bus.tc), et);
    chk({nm, " done"}, int'(bus.done), ed);
    chk({nm, " model"}, m_num, en);
  endtask

  initial begin
    int e2[5];
    n_cmp = 0; n_bad = 0; check_en = 1'b0;
    rst = 1'b0;
    bus.ena = 1'b0; bus.dir = 1'b1; bus.mode = 2'd0; bus.cant_ff = CW'(8);
    bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = 8'h00;
    repeat (3) edge_();
    check_en = 1'b1;
    pin("reset", 0, 0, 0);
    rst = 1'b1;

    // 1: k=4 up wrap, two periods
    bus.cant_ff = CW'(4); bus.dir = 1'b1; bus.mode = 2'd0; bus.ena = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 1; i <= 15; i++) begin
        edge_();
        pin("t1 count", i, (i == 15) ? 1 : 0, 0);
      end
      edge_();
      pin("t1 wrap", 0, 0, 0);
    end

    // 2: load 3, down, saturate
    bus.ena = 1'b0; bus.load = 1'b1; bus.load_val = 8'd3;
    edge_();
    pin("t2 load", 3, 0, 0);
    bus.load = 1'b0; bus.dir = 1'b0; bus.mode = 2'd1; bus.ena = 1'b1;
    e2 = '{2, 1, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      edge_();
      pin("t2 sat", e2[i], (i == 2) ? 1 : 0, 0);
    end

    // 3: k=3 up one-shot
    bus.ena = 1'b0; bus.clr = 1'b1; bus.cant_ff = CW'(3); bus.dir = 1'b1; bus.mode = 2'd2;
    edge_();
    bus.clr = 1'b0; bus.ena = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      edge_();
      pin("t3 count", i, (i == 7) ? 1 : 0, 0);
    end
    for (int i = 0; i < 6; i++) begin
      edge_();
      pin("t3 hold", 7, 0, 1);
    end
    bus.clr = 1'b1;
    edge_();
    pin("t3 clr", 0, 0, 0);
    bus.clr = 1'b0;

    // 4: load masking and mask-fix on cant_ff change
    bus.ena = 1'b0; bus.mode = 2'd0; bus.cant_ff = CW'(4); bus.load = 1'b1; bus.load_val = 8'hFF;
    edge_();
    pin("t4 load mask", 15, 0, 0);
    bus.cant_ff = CW'(8); bus.load_val = 8'hA5;
    edge_();
    pin("t4 load a5", 165, 0, 0);
    bus.load = 1'b0; bus.cant_ff = CW'(2);
    edge_();
    pin("t4 remask", 1, 0, 0);

    // 5: async reset mid-count
    bus.cant_ff = CW'(8); bus.dir = 1'b1; bus.clr = 1'b1;
    edge_();
    bus.clr = 1'b0; bus.ena = 1'b1;
    repeat (34) edge_();
    pin("t5 count", 34, 0, 0);
    #2 rst = 1'b0;
    #1 pin("t5 rst now", 0, 0, 0);
    repeat (3) begin
      edge_();
      pin("t5 rst hold", 0, 0, 0);
    end
    rst = 1'b1;
    edge_();
    pin("t5 release", 1, 0, 0);

    // 6: clr beats load; k=0 is inert
    bus.clr = 1'b1; bus.load = 1'b1; bus.load_val = 8'h5A;
    edge_();
    pin("t6 clr>load", 0, 0, 0);
    bus.clr = 1'b0; bus.load = 1'b0; bus.cant_ff = CW'(0); bus.ena = 1'b1;
    for (int i = 0; i < 10; i++) begin
      edge_();
      pin("t6 k0", 0, 0, 0);
    end

    // random phase, checked by the model process
    for (int i = 0; i < 3000; i++) begin
      bus.ena = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.dir = $urandom_range(0, 1);
      if ($urandom_range(0, 31) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 47) == 0) bus.cant_ff = CW'($urandom_range(0, 15));
      bus.clr = ($urandom_range(0, 49) == 0);
      bus.load = ($urandom_range(0, 24) == 0);
      bus.load_val = 8'($urandom);
      edge_();
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
